responder_arbiter: RTL and testbench

- Four-contestant buzzer arbiter for the quiz responder.
- Conditions four raw contestant keys, runs the answer window countdown, grants the first valid press and locks out the others.
- Records early presses as fouls; the host start/clear controls sequence each round.
- Outputs drive the winner LEDs, the countdown display and the buzzer logic.

---
 rtl/responder_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_responder_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/responder_arbiter.sv
// responder_arbiter: four-contestant quiz buzzer arbiter with foul tracking and answer-window countdown.
// Latency: key rise reaches a registered grant/foul on the 3rd clk edge; every output is registered.
// Backpressure: none; presses outside ARMED (other than IDLE fouls) are dropped, clear overrides all.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               host start pulse, arms a round from IDLE
//   clear               host round clear, returns to IDLE and wipes round results
//   key[3:0]            raw asynchronous contestant buttons, active-high
//   tick                1 Hz strobe driving the answer-window countdown
//   winner[3:0]         one-hot granted contestant, winner_valid while a grant is held
//   count[CW-1:0]       remaining seconds, timeout when the window expired ungranted
//   foul[3:0]           sticky early-press flags, busy while ARMED
//
// Optional: define ROTATE_PRIO_EN for a round-robin tie-break pointer that follows the
// last winner; without it key[0] always has the highest priority.
module responder_arbiter #(
   parameter int TIME_S = 9,
   parameter int CW     = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          clear,
   input  logic [3:0]    key,
   input  logic          tick,
   output logic [3:0]    winner,
   output logic          winner_valid,
   output logic [CW-1:0] count,
   output logic          timeout,
   output logic [3:0]    foul,
   output logic          busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    sync1_q, sync2_q, prev_q;
   logic [1:0]    settle_q;
   logic [3:0]    press, valid, sel_oh;
   logic [3:0]    winner_q, winner_d;
   logic [3:0]    foul_q, foul_d;
   logic          winner_valid_q, winner_valid_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] count_q, count_d;

   // Key conditioning: two-flop synchronizer followed by a rising-edge detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 4'b0000;
         sync2_q  <= 4'b0000;
         prev_q   <= 4'b0000;
         settle_q <= 2'd0;
      end else begin
         sync1_q <= key;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         if (settle_q != 2'd3) begin
            settle_q <= settle_q + 2'd1;
         end
      end
   end

   // The edge flop starts at 0, so a key already held when reset releases would
   // look like a fresh rise. Presses are masked until both the synchronizer and
   // the edge flop hold real post-reset samples.
   assign press = (settle_q == 2'd3) ? (sync2_q & ~prev_q) : 4'b0000;
   assign valid = press & ~foul_q;

`ifdef ROTATE_PRIO_EN
   logic [1:0] ptr_q, ptr_d, sel_idx, cand;

   // Scan from the farthest offset down so the nearest valid contestant to the
   // pointer is the one left standing.
   always_comb begin
      sel_oh  = 4'b0000;
      sel_idx = ptr_q;
      cand    = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_q + 2'(k);
         if (valid[cand]) begin
            sel_oh  = 4'b0001 << cand;
            sel_idx = cand;
         end
      end
   end

   // Pointer survives clear on purpose: fairness carries across rounds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 2'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Isolate the lowest set bit: key[0] wins every tie.
   assign sel_oh = valid & (~valid + 4'd1);
`endif

   always_comb begin
      state_d        = state_q;
      winner_d       = winner_q;
      winner_valid_d = winner_valid_q;
      count_d        = count_q;
      timeout_d      = timeout_q;
      foul_d         = foul_q;
`ifdef ROTATE_PRIO_EN
      ptr_d          = ptr_q;
`endif
      if (clear) begin
         // Overrides everything, including a press landing on the same cycle.
         state_d        = ST_IDLE;
         winner_d       = 4'b0000;
         winner_valid_d = 1'b0;
         count_d        = '0;
         timeout_d      = 1'b0;
         foul_d         = 4'b0000;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               foul_d = foul_q | press;
               if (start) begin
                  count_d = CW'(TIME_S);
                  state_d = ST_ARMED;
               end
            end
            ST_ARMED: begin
               // A press beats a simultaneous final tick.
               if (valid != 4'b0000) begin
                  winner_d       = sel_oh;
                  winner_valid_d = 1'b1;
                  state_d        = ST_LOCKED;
`ifdef ROTATE_PRIO_EN
                  ptr_d          = sel_idx + 2'd1;
`endif
               end else if (tick) begin
                  if (count_q > CW'(1)) begin
                     count_d = count_q - CW'(1);
                  end else begin
                     count_d   = '0;
                     timeout_d = 1'b1;
                     state_d   = ST_TIMEOUT;
                  end
               end
            end
            default: begin
               // LOCKED and TIMEOUT hold until clear.
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         winner_q       <= 4'b0000;
         winner_valid_q <= 1'b0;
         count_q        <= '0;
         timeout_q      <= 1'b0;
         foul_q         <= 4'b0000;
      end else begin
         state_q        <= state_d;
         winner_q       <= winner_d;
         winner_valid_q <= winner_valid_d;
         count_q        <= count_d;
         timeout_q      <= timeout_d;
         foul_q         <= foul_d;
      end
   end

   assign winner       = winner_q;
   assign winner_valid = winner_valid_q;
   assign count        = count_q;
   assign timeout      = timeout_q;
   assign foul         = foul_q;
   assign busy         = (state_q == ST_ARMED);

endmodule

// File: tb/tb_responder_arbiter.sv
// tb_responder_arbiter: self-checking bench for the quiz buzzer arbiter.
// Latency: inputs driven 1 ns after a rising edge, outputs compared 1 ns after the next one.
// Backpressure: n/a; the bench free-runs a fixed number of cycles and always reaches its summary.
`timescale 1ns/1ps
module tb_responder_arbiter;
   localparam int TIME_S = 9;
   localparam int CW     = 4;
   localparam int OW     = 11 + CW;
`ifdef ROTATE_PRIO_EN
   localparam int TIE2 = 4;
`else
   localparam int TIE2 = 1;
`endif
   localparam int P_IDLE = 0, P_ARMED = 1, P_LOCKED = 2, P_TIMEOUT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, clear = 1'b0, tick = 1'b0;
   logic [3:0]    key = 4'b0000;
   logic [3:0]    winner, foul;
   logic          winner_valid, timeout, busy;
   logic [CW-1:0] count;

   responder_arbiter #(.TIME_S(TIME_S), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .key(key), .tick(tick),
      .winner(winner), .winner_valid(winner_valid), .count(count), .timeout(timeout),
      .foul(foul), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: round phase, results, and a short history of key samples.
   logic [3:0] m_win, m_foul;
   logic       m_wv, m_to;
   int         m_count, m_phase, m_ptr;
   logic [3:0] samp[$];

   function automatic void model_reset();
      m_win = 4'b0000; m_foul = 4'b0000; m_wv = 1'b0; m_to = 1'b0;
      m_count = 0; m_phase = P_IDLE; m_ptr = 0;
      samp.delete();
   endfunction

   // A press needs a low sample followed by a high sample, both taken after
   // reset, and is acted on two edges after the high sample.
   function automatic void model_edge();
      logic [3:0] pr, v;
      int pick, base, idx;
      samp.push_back(key);
      if (samp.size() > 4) void'(samp.pop_front());
      pr = (samp.size() == 4) ? (samp[1] & ~samp[0]) : 4'b0000;
      if (clear) begin
         m_win = 4'b0000; m_foul = 4'b0000; m_wv = 1'b0; m_to = 1'b0;
         m_count = 0; m_phase = P_IDLE;
         return;
      end
      case (m_phase)
         P_IDLE: begin
            m_foul = m_foul | pr;
            if (start) begin
               m_count = TIME_S;
               m_phase = P_ARMED;
            end
         end
         P_ARMED: begin
            v = pr & ~m_foul;
            if (v != 4'b0000) begin
`ifdef ROTATE_PRIO_EN
               base = m_ptr;
`else
               base = 0;
`endif
               pick = -1;
               for (int k = 0; k < 4; k++) begin
                  idx = (base + k) % 4;
                  if (pick < 0 && v[idx]) pick = idx;
               end
               m_win = 4'(1 << pick);
               m_wv = 1'b1;
               m_ptr = (pick + 1) % 4;
               m_phase = P_LOCKED;
            end else if (tick) begin
               if (m_count > 1) m_count = m_count - 1;
               else begin
                  m_count = 0; m_to = 1'b1; m_phase = P_TIMEOUT;
               end
            end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [OW-1:0] model_out();
      return {m_win, m_wv, CW'(m_count), m_to, m_foul, (m_phase == P_ARMED)};
   endfunction

   function automatic logic [OW-1:0] pk(input int w, input int v, input int c,
                                        input int t, input int f, input int b);
      return {4'(w), 1'(v), CW'(c), 1'(t), 4'(f), 1'(b)};
   endfunction

   logic [OW-1:0] dut_out;
   assign dut_out = {winner, winner_valid, count, timeout, foul, busy};

   task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got win=%b vld=%b cnt=%0d to=%b foul=%b busy=%b, expected win=%b vld=%b cnt=%0d to=%b foul=%b busy=%b",
                  name, got[OW-1:OW-4], got[OW-5], got[CW+5:6], got[5], got[4:1], got[0],
                  exp[OW-1:OW-4], exp[OW-5], exp[CW+5:6], exp[5], exp[4:1], exp[0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   typedef struct {
      logic st, cl, tk;
      logic [3:0] k;
      logic [OW-1:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input int st, input int cl, input int tk, input int k,
                               input int w, input int v, input int c, input int t,
                               input int f, input int b);
      vec_t r;
      r.st = 1'(st); r.cl = 1'(cl); r.tk = 1'(tk); r.k = 4'(k);
      r.exp = pk(w, v, c, t, f, b);
      tbl.push_back(r);
   endfunction

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", dut_out, pk(0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
      repeat (4) step();
      check("idle_after_reset", dut_out, pk(0, 0, 0, 0, 0, 0));

      // Clean round: key[2] five cycles after start, later presses/ticks/start ignored.
      add(1, 0, 0, 0, 0, 0, 9, 0, 0, 1);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 9, 0, 0, 1);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0100, 0, 0, 9, 0, 0, 1);
      add(0, 0, 0, 4'b0100, 4'b0100, 1, 9, 0, 0, 0);
      add(0, 0, 0, 0, 4'b0100, 1, 9, 0, 0, 0);
      add(1, 0, 0, 4'b0001, 4'b0100, 1, 9, 0, 0, 0);
      add(0, 0, 0, 4'b0001, 4'b0100, 1, 9, 0, 0, 0);
      add(0, 0, 1, 4'b0001, 4'b0100, 1, 9, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Timeout round, with a start inside ARMED that must not reload the count.
      add(1, 0, 0, 0, 0, 0, 9, 0, 0, 1);
      for (int j = 1; j <= 8; j++) add((j == 3) ? 1 : 0, 0, 1, 0, 0, 0, 9 - j, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Foul on key[1] in IDLE, then key[1]+key[3] together: key[3] wins.
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0);
      add(1, 0, 0, 0, 0, 0, 9, 0, 4'b0010, 1);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b1010, 0, 0, 9, 0, 4'b0010, 1);
      add(0, 0, 0, 4'b1010, 4'b1000, 1, 9, 0, 4'b0010, 0);
      add(0, 0, 0, 0, 4'b1000, 1, 9, 0, 4'b0010, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Tie key[0]+key[2]: twice, the second after a key[0] win.
      add(1, 0, 0, 0, 0, 0, 9, 0, 0, 1);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0101, 0, 0, 9, 0, 0, 1);
      add(0, 0, 0, 4'b0101, 4'b0001, 1, 9, 0, 0, 0);
      add(0, 0, 0, 0, 4'b0001, 1, 9, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 9, 0, 0, 1);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0101, 0, 0, 9, 0, 0, 1);
      add(0, 0, 0, 4'b0101, TIE2, 1, 9, 0, 0, 0);
      add(0, 0, 0, 0, TIE2, 1, 9, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Press coincident with the final tick: grant wins, count stays 1.
      add(1, 0, 0, 0, 0, 0, 9, 0, 0, 1);
      for (int j = 1; j <= 8; j++) add(0, 0, 1, 0, 0, 0, 9 - j, 0, 0, 1);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0001, 0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 4'b0001, 4'b0001, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 4'b0001, 1, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Clear in LOCKED with foul=0001, press on the clear cycle discarded, re-arm.
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 4'b0001, 0, 0, 0, 0, 4'b0001, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0);
      add(1, 0, 0, 0, 0, 0, 9, 0, 4'b0001, 1);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0100, 0, 0, 9, 0, 4'b0001, 1);
      add(0, 0, 0, 4'b0100, 4'b0100, 1, 9, 0, 4'b0001, 0);
      add(0, 0, 0, 0, 4'b0100, 1, 9, 0, 4'b0001, 0);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0010, 4'b0100, 1, 9, 0, 4'b0001, 0);
      add(0, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 9, 0, 0, 1);
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         start = tbl[i].st; clear = tbl[i].cl; tick = tbl[i].tk; key = tbl[i].k;
         step();
         check($sformatf("table_row%0d", i), dut_out, tbl[i].exp);
      end
      start = 1'b0; clear = 1'b0; tick = 1'b0; key = 4'b0000;

      // Asynchronous reset in the middle of ARMED.
      start = 1'b1; step(); start = 1'b0; step();
      check("armed_before_reset", dut_out, pk(0, 0, 9, 0, 0, 1));
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_reset_mid_armed", dut_out, pk(0, 0, 0, 0, 0, 0));

      // Key held across reset release: no press until it falls and rises again.
      key = 4'b0001;
      step(); step();
      rst_n = 1'b1;
      repeat (3) step();
      start = 1'b1; step(); start = 1'b0;
      repeat (4) step();
      check("held_key_no_press", dut_out, pk(0, 0, 9, 0, 0, 1));
      key = 4'b0000; repeat (2) step();
      key = 4'b0001; repeat (2) step();
      check("repress_two_edges", dut_out, pk(0, 0, 9, 0, 0, 1));
      step();
      check("repress_third_edge", dut_out, pk(4'b0001, 1, 9, 0, 0, 0));
      key = 4'b0000; clear = 1'b1; step(); clear = 1'b0;
      check("model_sync_after_hand", dut_out, model_out());

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 7) == 0);
         clear = ($urandom_range(0, 39) == 0);
         tick  = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 9) == 0) key[b] = ~key[b];
         end
         step();
         check($sformatf("random_cycle%0d", c), dut_out, model_out());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
